// File: rtl/riscv_core_pkg.sv
// Shared definitions for the RV32 core: RV32 load/store funct3 encodings and LSU state type.
package riscv_core_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // funct3[1:0] encodes the access width for both loads and stores
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_t;

endpackage

// File: rtl/riscv_core_lsu_align.sv
// Combinational data-path of the LSU: store byte-lane steering / enables and load extraction / extension.
module riscv_core_lsu_align
  import riscv_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      st_funct3,
  input  logic [1:0]      st_offset,
  input  logic [XLEN-1:0] st_data,
  output logic [3:0]      st_be,
  output logic [XLEN-1:0] st_wdata,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_offset,
  input  logic [XLEN-1:0] ld_word,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] ld_shifted;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_funct3[1:0])
      SIZE_B: begin
        st_be    = 4'b0001 << st_offset;
        st_wdata = {4{st_data[7:0]}};
      end
      SIZE_H: begin
        st_be    = st_offset[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  // Bring the addressed byte/half down to bit 0 before extending
  assign ld_shifted = ld_word >> {ld_offset, 3'b000};

  always_comb begin
    ld_data = ld_word;
    case (ld_funct3)
      LB:      ld_data = {{(XLEN-8){ld_shifted[7]}}, ld_shifted[7:0]};
      LH:      ld_data = {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
      LBU:     ld_data = {{(XLEN-8){1'b0}}, ld_shifted[7:0]};
      LHU:     ld_data = {{(XLEN-16){1'b0}}, ld_shifted[15:0]};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/riscv_core_lsu.sv
// Memory-stage load/store unit: single-outstanding req/gnt/rvalid data-memory access with pipeline stall.
module riscv_core_lsu
  import riscv_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_lsu_valid,
  input  logic            i_lsu_load,
  input  logic            i_lsu_store,
  input  logic [2:0]      i_lsu_funct3,
  input  logic [XLEN-1:0] i_lsu_addr,
  input  logic [XLEN-1:0] i_lsu_wdata,
  output logic            o_lsu_stall,
  output logic            o_lsu_done,
  output logic [XLEN-1:0] o_lsu_rdata,
  output logic            o_lsu_misalign,
  output logic            o_lsu_illegal,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [3:0]      o_dmem_be,
  output logic [XLEN-1:0] o_dmem_wdata,
  input  logic            i_dmem_gnt,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata
);

  lsu_state_t state, state_next;

  logic [XLEN-1:0] cap_addr;
  logic [XLEN-1:0] cap_wdata;
  logic [2:0]      cap_funct3;
  logic [3:0]      cap_be;
  logic            cap_we;
  logic [XLEN-1:0] rdata_q;

  logic            mem_op;
  logic            misalign;
  logic            illegal;
  logic            start;
  logic [3:0]      steer_be;
  logic [XLEN-1:0] steer_wdata;
  logic [XLEN-1:0] load_data;

  assign mem_op = i_lsu_valid & (i_lsu_load | i_lsu_store);

  always_comb begin
    misalign = 1'b0;
    case (i_lsu_funct3[1:0])
      SIZE_H:  misalign = i_lsu_addr[0];
      SIZE_W:  misalign = |i_lsu_addr[1:0];
      default: misalign = 1'b0;
    endcase
  end

  always_comb begin
    illegal = 1'b0;
    if (i_lsu_load) begin
      illegal = (i_lsu_funct3 == 3'b011) | (i_lsu_funct3 == 3'b110) | (i_lsu_funct3 == 3'b111);
    end else if (i_lsu_store) begin
      illegal = i_lsu_funct3[2] | (i_lsu_funct3[1:0] == 2'b11);
    end
  end

  assign o_lsu_misalign = mem_op & misalign;
  assign o_lsu_illegal  = mem_op & illegal;
  assign start          = mem_op & ~misalign & ~illegal;

  riscv_core_lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .st_funct3 (i_lsu_funct3),
    .st_offset (i_lsu_addr[1:0]),
    .st_data   (i_lsu_wdata),
    .st_be     (steer_be),
    .st_wdata  (steer_wdata),
    .ld_funct3 (cap_funct3),
    .ld_offset (cap_addr[1:0]),
    .ld_word   (i_dmem_rdata),
    .ld_data   (load_data)
  );

  always_comb begin
    state_next  = state;
    o_lsu_stall = 1'b0;
    o_dmem_req  = 1'b0;
    o_lsu_done  = 1'b0;
    case (state)
      IDLE: begin
        o_lsu_stall = start;
        if (start) state_next = REQ;
      end
      REQ: begin
        o_lsu_stall = 1'b1;
        o_dmem_req  = 1'b1;
        if (i_dmem_gnt) state_next = WAIT;
      end
      WAIT: begin
        o_lsu_stall = 1'b1;
        if (i_dmem_rvalid) state_next = DONE;
      end
      DONE: begin
        o_lsu_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture registers hold the bus-side fields stable for the whole REQ/WAIT window
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_funct3 <= '0;
      cap_be     <= '0;
      cap_we     <= 1'b0;
    end else if (state == IDLE && start) begin
      cap_addr   <= i_lsu_addr;
      cap_wdata  <= steer_wdata;
      cap_funct3 <= i_lsu_funct3;
      cap_be     <= steer_be;
      cap_we     <= i_lsu_store;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdata_q <= '0;
    end else if (state == WAIT && i_dmem_rvalid && !cap_we) begin
      rdata_q <= load_data;
    end
  end

  assign o_lsu_rdata  = rdata_q;
  assign o_dmem_we    = cap_we;
  assign o_dmem_addr  = {cap_addr[XLEN-1:2], 2'b00};
  assign o_dmem_be    = cap_be;
  assign o_dmem_wdata = cap_wdata;

endmodule

// File: tb/tb_riscv_core_lsu.sv
// Randomized self-checking bench for riscv_core_lsu against a behavioural access model.
module tb_riscv_core_lsu;
  import riscv_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsu_valid = 1'b0;
  logic        lsu_load = 1'b0;
  logic        lsu_store = 1'b0;
  logic [2:0]  lsu_funct3 = '0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic        lsu_stall, lsu_done, lsu_misalign, lsu_illegal;
  logic [31:0] lsu_rdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_rdata = '0;

  always #5 clk = ~clk;

  riscv_core_lsu #(
    .XLEN(32)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_lsu_valid   (lsu_valid),
    .i_lsu_load    (lsu_load),
    .i_lsu_store   (lsu_store),
    .i_lsu_funct3  (lsu_funct3),
    .i_lsu_addr    (lsu_addr),
    .i_lsu_wdata   (lsu_wdata),
    .o_lsu_stall   (lsu_stall),
    .o_lsu_done    (lsu_done),
    .o_lsu_rdata   (lsu_rdata),
    .o_lsu_misalign(lsu_misalign),
    .o_lsu_illegal (lsu_illegal),
    .o_dmem_req    (dmem_req),
    .o_dmem_we     (dmem_we),
    .o_dmem_addr   (dmem_addr),
    .o_dmem_be     (dmem_be),
    .o_dmem_wdata  (dmem_wdata),
    .i_dmem_gnt    (dmem_gnt),
    .i_dmem_rvalid (dmem_rvalid),
    .i_dmem_rdata  (dmem_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int off = int'(addr % 4);
    case (int'(f3 % 4))
      0:       return 4'(1 << off);
      1:       return (off >= 2) ? 4'd12 : 4'd3;
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (int'(f3 % 4))
      0:       return (wd & 32'hFF) * 32'h0101_0101;
      1:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    int unsigned sh = 8 * (addr % 4);
    int unsigned b  = (word >> sh) & 32'hFF;
    int unsigned h  = (word >> sh) & 32'hFFFF;
    case (f3)
      LB:      return (b >= 128) ? 32'(int'(b) - 256) : 32'(b);
      LH:      return (h >= 32768) ? 32'(int'(h) - 65536) : 32'(h);
      LBU:     return 32'(b);
      LHU:     return 32'(h);
      default: return word;
    endcase
  endfunction

  function automatic bit model_illegal(input bit is_load, input logic [2:0] f3);
    if (is_load) return (f3 == 3) || (f3 == 6) || (f3 == 7);
    return f3 > 2;
  endfunction

  function automatic bit model_misalign(input logic [2:0] f3, input logic [31:0] addr);
    if (f3 == LH || f3 == LHU) return (addr % 2) != 0;
    if (f3 == LW) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  task automatic present(input bit is_load, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
    lsu_valid  = 1'b1;
    lsu_load   = is_load;
    lsu_store  = !is_load;
    lsu_funct3 = f3;
    lsu_addr   = addr;
    lsu_wdata  = wd;
  endtask

  task automatic run_access(input bit is_load, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rword,
                            input int gnt_dly, input int rv_dly);
    logic [31:0] e_rdata;
    @(posedge clk); #1;
    present(is_load, f3, addr, wd);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    @(negedge clk);
    check_eq("idle_stall", 32'(lsu_stall), 1);
    check_eq("idle_req", 32'(dmem_req), 0);
    for (int k = 0; k <= gnt_dly; k++) begin
      @(posedge clk); #1;
      dmem_gnt    = (k == gnt_dly);
      dmem_rvalid = (k != gnt_dly) && ($urandom_range(0, 1) == 1);
      dmem_rdata  = $urandom;
      @(negedge clk);
      check_eq("req_req", 32'(dmem_req), 1);
      check_eq("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
      check_eq("req_be", 32'(dmem_be), 32'(model_be(f3, addr)));
      check_eq("req_we", 32'(dmem_we), 32'(!is_load));
      if (!is_load) check_eq("req_wdata", dmem_wdata, model_wdata(f3, wd));
      check_eq("req_stall", 32'(lsu_stall), 1);
      check_eq("req_done", 32'(lsu_done), 0);
    end
    for (int j = 1; j <= rv_dly; j++) begin
      @(posedge clk); #1;
      dmem_gnt    = 1'b0;
      dmem_rvalid = (j == rv_dly);
      dmem_rdata  = (j == rv_dly) ? rword : $urandom;
      @(negedge clk);
      check_eq("wait_req", 32'(dmem_req), 0);
      check_eq("wait_stall", 32'(lsu_stall), 1);
      check_eq("wait_done", 32'(lsu_done), 0);
    end
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    dmem_rdata  = $urandom;
    @(negedge clk);
    e_rdata = is_load ? model_load(f3, addr, rword) : last_rdata;
    last_rdata = e_rdata;
    check_eq("done_pulse", 32'(lsu_done), 1);
    check_eq("done_stall", 32'(lsu_stall), 0);
    check_eq("done_req", 32'(dmem_req), 0);
    check_eq("done_rdata", lsu_rdata, e_rdata);
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    @(negedge clk);
    check_eq("post_done", 32'(lsu_done), 0);
    check_eq("post_req", 32'(dmem_req), 0);
    check_eq("post_stall", 32'(lsu_stall), 0);
    check_eq("post_rdata", lsu_rdata, last_rdata);
  endtask

  task automatic run_fault(input bit is_load, input logic [2:0] f3, input logic [31:0] addr);
    bit e_ill, e_mis;
    e_ill = model_illegal(is_load, f3);
    e_mis = model_misalign(f3, addr);
    @(posedge clk); #1;
    present(is_load, f3, addr, $urandom);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    @(negedge clk);
    check_eq("flt_illegal", 32'(lsu_illegal), 32'(e_ill));
    if (!e_ill) check_eq("flt_misalign", 32'(lsu_misalign), 32'(e_mis));
    check_eq("flt_stall", 32'(lsu_stall), 0);
    check_eq("flt_req", 32'(dmem_req), 0);
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    @(negedge clk);
    check_eq("flt_noreq", 32'(dmem_req), 0);
    check_eq("flt_nostall", 32'(lsu_stall), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_stall", 32'(lsu_stall), 0);
    check_eq("rst_req", 32'(dmem_req), 0);
    check_eq("rst_done", 32'(lsu_done), 0);
    check_eq("rst_rdata", lsu_rdata, 0);
    check_eq("rst_addr", dmem_addr, 0);

    run_access(1'b0, SW, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 1);
    run_access(1'b0, SB, 32'h203, 32'h0000_00A5, 32'h0, 0, 1);
    run_access(1'b1, LB, 32'h302, 32'h0, 32'h0080_0000, 0, 1);
    run_access(1'b1, LBU, 32'h302, 32'h0, 32'h0080_0000, 0, 1);
    run_fault(1'b1, LH, 32'h101);
    run_fault(1'b1, LW, 32'h102);
    run_fault(1'b1, 3'b011, 32'h100);
    run_access(1'b1, LW, 32'h500, 32'h0, 32'h1234_5678, 3, 2);

    // Reset asserted while the access sits in WAIT
    @(posedge clk); #1;
    present(1'b1, LW, 32'h400, 32'h0);
    @(posedge clk); #1;
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_stall", 32'(lsu_stall), 1);
    #2;
    rst = 1'b1;
    lsu_valid = 1'b0;
    #1;
    check_eq("midrst_req", 32'(dmem_req), 0);
    check_eq("midrst_stall", 32'(lsu_stall), 0);
    check_eq("midrst_done", 32'(lsu_done), 0);
    check_eq("midrst_rdata", lsu_rdata, 0);
    last_rdata = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_access(1'b1, LW, 32'h404, 32'h0, 32'hCAFE_F00D, 0, 1);

    for (int n = 0; n < 60; n++) begin
      bit          is_load;
      logic [2:0]  f3;
      logic [31:0] addr;
      is_load = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (is_load) begin
        case ($urandom_range(0, 4))
          0: f3 = LB;
          1: f3 = LH;
          2: f3 = LW;
          3: f3 = LBU;
          default: f3 = LHU;
        endcase
      end else f3 = 3'($urandom_range(0, 2));
      addr = $urandom & 32'h0000_FFFF;
      if (model_illegal(is_load, f3) || model_misalign(f3, addr))
        run_fault(is_load, f3, addr);
      else
        run_access(is_load, f3, addr, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
